vram_fetch_arbiter: RTL
=======================

// Module: vram_fetch_arbiter
// PURPOSE
// Shares one single-port text VRAM (2 KB, 1-cycle sync read) between the display and the CPU, on pixclk.
// Display side: uses the HDMI timing generator's counters, prefetches one character code and one font byte per cell.
// It drives a 1-bit pixel stream, gated into red/green/blue ahead of the TMDS encoders.
// CPU side: req/ack handshake, granted every cycle the display does not own the port.
// PARAMETERS
// H_START    160  hcnt value of first visible pixel
// V_START    29   vcnt value of first visible line
// COLS       64   character columns (COLS*ROWS must equal 2048)
// ROWS       32   character rows
// CELL_W     16   pixclk cycles per character cell; power of 2, >=8; each glyph bit held CELL_W/8 cycles
// LINE_REP   3    scanlines per glyph row; a character row is 8*LINE_REP scanlines
// PORTS
// pixclk     in   1   pixel clock
// n_rst      in   1   asynchronous reset, active low
// hcnt       in   11  horizontal counter from timing generator
// vcnt       in   11  vertical counter from timing generator
// cpu_req    in   1   CPU access request, held high until cpu_ack
// cpu_we     in   1   1=write, 0=read; stable while cpu_req
// cpu_addr   in   11  VRAM address; stable while cpu_req
// cpu_wdata  in   8   write data; stable while cpu_req
// cpu_ack    out  1   one-cycle completion pulse
// cpu_rdata  out  8   read data, valid in the cpu_ack cycle
// mem_addr   out  11  VRAM address
// mem_we     out  1   VRAM write strobe
// mem_wdata  out  8   VRAM write data
// mem_rdata  in   8   VRAM read data, 1 cycle after mem_addr
// font_addr  out  11  {char_code, glyph_row[2:0]}
// font_data  in   8   font byte, 1 cycle after font_addr, MSB = leftmost pixel
// pix_on     out  1   current pixel lit
// BEHAVIOUR
// - Reset: all outputs 0; counters, shift/holding regs and CPU FSM cleared; any in-flight CPU request is dropped and must be re-issued.
// - Line counters: update only at hcnt==0.
//   - vcnt==V_START: row=0, rep=0, glyph=0.
//   - Otherwise, while active: rep wraps at LINE_REP-1, which increments glyph; glyph wraps at 7, which increments row.
//   - Active lines: V_START <= vcnt < V_START+ROWS*8*LINE_REP.
// - Fetch window: on active lines, H_START-CELL_W <= hcnt < H_START+(COLS-1)*CELL_W; phase = (hcnt-(H_START-CELL_W)) mod CELL_W.
// - Within the window, the cell fetched is col+1, one cell ahead:
//   - phase 0: display owns port; mem_addr = row*COLS + fcol, mem_we=0.
//   - phase 1: code <= mem_rdata; font_addr = {code, glyph}.
//   - phase 2: hold <= font_data.
//   - phase CELL_W-1: shift <= hold.
//   - Shift register moves left once every CELL_W/8 cycles.
// - pix_on = shift[7] registered, so it is 1-cycle late, aligned with the timing generator's registered visible.
// - pix_on is forced 0 outside active lines/columns.
// - CPU FSM:
//   - IDLE -> GRANT when cpu_req=1 and the display does not own this cycle; mem_* driven from cpu_*.
//   - Write: GRANT -> ACK; cpu_ack=1 for one cycle, then IDLE.
//   - Read: GRANT -> ACK; cpu_rdata <= mem_rdata, cpu_ack=1.
//   - In ACK, a still-high cpu_req is not re-granted; IDLE is re-entered first.
// - Collision: if cpu_req and display phase 0 coincide, the display wins and the CPU is granted next cycle.
//   - Worst-case latency, req to ack: 3 cycles.
// - cpu_req dropped before ack: protocol violation, undefined.
// - Blanking: the CPU owns every cycle.
// - A CPU write to the cell being fetched in the same cell: the display sees old or new data, never corrupt.
// TESTING
// 1. Reset mid-CPU-read (n_rst low in GRANT) -> cpu_ack never pulses; all outputs 0 the cycle after n_rst falls.
// 2. Blanking, read addr 0x123 holding 0x5A -> cpu_ack 2 cycles after req, cpu_rdata=0x5A; write 0xA5 -> ack 2 cycles after req, mem_we one cycle.
// 3. cpu_req rises exactly at phase 0 in active line -> mem_addr shows display addr, CPU granted next cycle, ack 3 cycles after req.
// 4. VRAM addr 0 = 0x41, font 'A' row0 = 0x18, vcnt=29 -> pix_on=1 only for the cycles after hcnt=166..169; font_addr=0x208 at phase 1.
// 5. Frame scan -> mem_addr display reads cover 0..2047 once per glyph line set; row 31 ends at vcnt=796; vcnt=797 gives pix_on=0.
// 6. Continuous CPU writes throughout a full active line -> every display phase-0 fetch is correct, and no CPU request waits more than 3 cycles.

Source files
------------

// File: rtl/vram_fetch_arbiter.sv
// rtl/vram_fetch_arbiter.sv - text-mode VRAM port arbiter: display prefetch plus CPU req/ack access
//
// One single-port text VRAM is shared between the character display and
// the CPU. On active lines the display takes the port for one cycle per
// character cell (phase 0), one cell ahead of the beam. The CPU gets the
// port in every other cycle.
//
// Ports:
//   pixclk, n_rst          pixel clock, asynchronous active-low reset
//   hcnt, vcnt             counters from the HDMI timing generator
//   cpu_req/we/addr/wdata  CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata     one-cycle completion pulse, read data in that cycle
//   mem_addr/we/wdata      VRAM port, mem_rdata returns one cycle after mem_addr
//   font_addr, font_data   font ROM {char_code, glyph_row}, data one cycle later
//   pix_on                 current pixel lit, one cycle after the beam position
module vram_fetch_arbiter #(
   parameter int H_START  = 160,
   parameter int V_START  = 29,
   parameter int COLS     = 64,
   parameter int ROWS     = 32,
   parameter int CELL_W   = 16,
   parameter int LINE_REP = 3
) (
   input  logic        pixclk,
   input  logic        n_rst,
   input  logic [10:0] hcnt,
   input  logic [10:0] vcnt,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [10:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [10:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        pix_on
);

   localparam int PW   = $clog2(CELL_W);
   localparam int CW   = $clog2(COLS);
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int REPW = (LINE_REP > 1) ? $clog2(LINE_REP) : 1;

   localparam logic [10:0] WIN_LO = 11'(H_START - CELL_W);
   localparam logic [10:0] WIN_HI = 11'(H_START + (COLS - 1) * CELL_W);
   localparam logic [10:0] VIS_LO = 11'(H_START);
   localparam logic [10:0] VIS_HI = 11'(H_START + COLS * CELL_W);
   localparam logic [10:0] V_LO   = 11'(V_START);
   localparam logic [10:0] V_HI   = 11'(V_START + ROWS * 8 * LINE_REP);

   localparam logic [PW-1:0]   PH_ZERO  = '0;
   localparam logic [PW-1:0]   PH_ONE   = PW'(1);
   localparam logic [PW-1:0]   PH_TWO   = PW'(2);
   localparam logic [PW-1:0]   PH_LAST  = PW'(CELL_W - 1);
   localparam logic [PW-1:0]   SH_MASK  = PW'(CELL_W / 8 - 1);
   localparam logic [REPW-1:0] REP_LAST = REPW'(LINE_REP - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_ACK
   } state_t;

   state_t          state, state_nx;
   logic            run;
   logic [RW-1:0]   row;
   logic [REPW-1:0] rep;
   logic [2:0]      glyph;
   logic [7:0]      code, hold, shift;
   logic [10:0]     hoff;
   logic [PW-1:0]   phase;
   logic [CW-1:0]   fcol;
   logic [10:0]     disp_addr;
   logic            active_line, in_win, in_vis, disp_own, shift_step, cpu_grant;

   // Offset from the start of the fetch window; its low bits are the cell
   // phase, which lines up with the visible cells because the window starts
   // exactly one cell early.
   assign hoff        = hcnt - WIN_LO;
   assign phase       = PW'(hoff);
   assign fcol        = CW'(hoff >> PW);
   assign active_line = (vcnt >= V_LO) && (vcnt < V_HI);
   assign in_win      = active_line && (hcnt >= WIN_LO) && (hcnt < WIN_HI);
   assign in_vis      = active_line && (hcnt >= VIS_LO) && (hcnt < VIS_HI);
   assign shift_step  = (phase & SH_MASK) == SH_MASK;
   assign disp_addr   = 11'(row) * 11'(COLS) + 11'(fcol);

   // run stays low for the first cycle after reset release so that every
   // combinational output is 0 while n_rst is low, whatever the inputs do.
   assign disp_own    = run && in_win && (phase == PH_ZERO);

   always_ff @(posedge pixclk or negedge n_rst) begin
      if (!n_rst) begin
         row   <= '0;
         rep   <= '0;
         glyph <= '0;
      end else if (hcnt == '0) begin
         if (vcnt == V_LO) begin
            row   <= '0;
            rep   <= '0;
            glyph <= '0;
         end else if (active_line) begin
            if (rep == REP_LAST) begin
               rep <= '0;
               if (glyph == 3'd7) begin
                  glyph <= '0;
                  row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
               end else begin
                  glyph <= glyph + 3'd1;
               end
            end else begin
               rep <= rep + REPW'(1);
            end
         end
      end
   end

   always_ff @(posedge pixclk or negedge n_rst) begin
      if (!n_rst) begin
         code   <= '0;
         hold   <= '0;
         shift  <= '0;
         pix_on <= 1'b0;
      end else begin
         if (in_win && phase == PH_ONE) code <= mem_rdata;
         if (in_win && phase == PH_TWO) hold <= font_data;
         // The next glyph byte lands on the last phase so its MSB is in
         // shift[7] on the first cycle of the cell.
         if (in_win && phase == PH_LAST)
            shift <= hold;
         else if (shift_step)
            shift <= {shift[6:0], 1'b0};
         pix_on <= in_vis && shift[7];
      end
   end

   always_ff @(posedge pixclk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_IDLE;
         cpu_rdata <= '0;
         run       <= 1'b0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
         if (state == S_GRANT && !cpu_we) cpu_rdata <= mem_rdata;
      end
   end

   always_comb begin
      state_nx  = state;
      cpu_grant = 1'b0;
      case (state)
         S_IDLE: begin
            if (run && cpu_req && !disp_own) begin
               cpu_grant = 1'b1;
               state_nx  = S_GRANT;
            end
         end
         S_GRANT: state_nx = S_ACK;
         S_ACK:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      font_addr = '0;
      cpu_ack   = (state == S_ACK);
      if (disp_own) begin
         mem_addr = disp_addr;
      end else if (cpu_grant) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end
      // On phase 1 the code is still on mem_rdata, so it is forwarded
      // straight to the font ROM; afterwards the latched copy holds it.
      if (run) begin
         if (in_win && phase == PH_ONE)
            font_addr = {mem_rdata, glyph};
         else
            font_addr = {code, glyph};
      end
   end

endmodule
